uart_tx_typed_chunk_arbiter: RTL and testbench
==============================================

// Module: uart_tx_typed_chunk_arbiter
// PURPOSE
//  Multi-channel successor of the single-buffer typed chunk sender. CHANNELS producers each offer a typed chunk.
//  A round-robin arbiter picks one and escape-encodes it into one byte stream for a single UART TX byte engine.
//  Adds clamped sizes, zero-length chunks, reserved-type rejection, per-channel ack/err and synchronous reset.
//  Wire format per chunk: 00 TT | payload with each 00 sent as 00 00 | 00 01.
// PARAMETERS
//  CHANNELS      2                          number of producer channels (>=1)
//  BUFFER_BYTES  4                          max payload bytes per chunk (>=1)
//  SIZE_W        $clog2(BUFFER_BYTES+1)     width of per-channel size field
//  CH_W          (CHANNELS>1)?$clog2(CHANNELS):1   width of channel index
// PORTS
//  CLK        in   1                    single clock; all logic on posedge
//  RST        in   1                    synchronous, active-high reset
//  ch_req     in   CHANNELS             level request; channel i chunk is valid
//  ch_size    in   CHANNELS*SIZE_W      payload byte count, channel i at [i*SIZE_W +: SIZE_W]
//  ch_type    in   CHANNELS*8           chunk type, channel i at [i*8 +: 8]
//  ch_bytes   in   CHANNELS*BUFFER_BYTES*8   payload; byte k of ch i at [(i*BUFFER_BYTES+k)*8 +: 8]
//  ch_ack     out  CHANNELS             1-cycle pulse: chunk of channel i fully sent
//  ch_err     out  CHANNELS             1-cycle pulse: chunk of channel i rejected (reserved type)
//  tx_valid   out  1                    1-cycle strobe: tx_data is to be sent
//  tx_data    out  8                    byte to UART TX; held stable until next strobe
//  tx_done    in   1                    1-cycle pulse from UART TX: last strobed byte finished
//  busy       out  1                    high from grant until ack/err cycle inclusive
//  active_ch  out  CH_W                 channel index of current/last grant
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer so channel 0 has top priority. tx_valid drops the cycle after RST.
//  Reset mid-chunk abandons it: no terminator, no ack. The receiver resyncs on the next 00 TT header.
//  FSM: IDLE -> GRANT -> (REJECT | LOAD) ; LOAD -> STROBE -> WAIT -> LOAD | ACK ; REJECT, ACK -> IDLE.
//  IDLE: if any ch_req, go to GRANT; active_ch = first requester after last granted index, wrapping.
//  GRANT: latch ch_type and min(ch_size, BUFFER_BYTES). Oversize is clamped silently, no err.
//   Type 00 or 01 -> REJECT: ch_err[active_ch]=1 for one cycle, no bytes emitted.
//  LOAD: choose next byte by phase HDR_ESC(00), HDR_TYPE(TT), PAYLOAD, EOC_ESC(00), EOC_VAL(01).
//   In PAYLOAD, a 00 byte is emitted twice: escape, then value. An esc_done flag gates the index increment.
//  STROBE: tx_valid=1 for exactly one cycle. WAIT: hold until tx_done; tx_done outside WAIT is ignored.
//  Payload index advances on tx_done of a non-escape payload byte. Length 0 skips PAYLOAD entirely.
//  ACK: ch_ack[active_ch]=1 for one cycle, then IDLE.
//   A ch_req still high after ack is a new chunk and re-arbitrates fairly: other requesters go first.
//  ch_bytes of the granted channel must stay stable from grant to ack; it is read live, not copied.
//   ch_size/ch_type are copied at GRANT.
//  ch_req dropped mid-chunk has no effect; the chunk completes.
//  Bytes on wire for n payload bytes, z of them 00 = n+z+4. Minimum per byte: 3 cycles + UART time.
//  Index counter width SIZE_W; no wrap possible due to clamp.
// STRUCTURE
//  Shared include typed_chunk_defs.vh: ESC_BYTE=8'h00, ESC_NULL=8'h00, ESC_EOC=8'h01, TYPE_MIN=8'h02,
//   FSM state and phase encodings (also used by the RX de-chunker).
//  Sub-module rr_arbiter #(N): req, advance, grant index/onehot, rotating pointer. Everything else stays flat.
// TESTING
//  1 ch0 type 02, size 3, bytes 01 00 03 -> tx 00 02 01 00 00 03 00 01; ch_ack[0] once after last tx_done.
//  2 ch1 type 05, size 0 -> tx 00 05 00 01; ch_ack[1]; busy low the cycle after ack.
//  3 ch0 type 01 -> ch_err[0] one cycle, zero tx_valid strobes, no ack; type 00 same.
//  4 ch0+ch1 held high, types 02/03 -> chunks alternate ch0,ch1,ch0,ch1; never two same-channel in a row.
//  5 BUFFER_BYTES=4, size 7, bytes AA BB CC DD -> tx 00 02 AA BB CC DD 00 01; no err.
//  6 RST during 2nd payload byte -> tx_valid 0 from next cycle, all outputs 0; next request starts with 00 TT.

Source files
------------

// File: rtl/uart_tx_typed_chunk_arbiter_pkg.sv
// Shared typed-chunk framing constants, FSM/phase encodings and helpers
// used by the multi-channel chunk sender (and the matching RX de-chunker).
package uart_tx_typed_chunk_arbiter_pkg;

  localparam logic [7:0] ESC_BYTE = 8'h00;
  localparam logic [7:0] ESC_NULL = 8'h00;
  localparam logic [7:0] ESC_EOC  = 8'h01;
  localparam logic [7:0] TYPE_MIN = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_REJECT,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic [2:0] {
    PH_HDR_ESC,
    PH_HDR_TYPE,
    PH_PAYLOAD,
    PH_EOC_ESC,
    PH_EOC_VAL
  } phase_t;

  // Types below TYPE_MIN collide with the escape codes and cannot be framed.
  function automatic logic is_reserved(input logic [7:0] chunk_type);
    return chunk_type < TYPE_MIN;
  endfunction

endpackage

// File: rtl/uart_tx_typed_chunk_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
// The pointer only moves when the caller accepts a grant via advance.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_oh,
  output logic         any_req
);

  logic [W-1:0] ptr;
  logic         found;
  int unsigned  cand;

  assign any_req = |req;

  always_comb begin
    grant_idx = '0;
    grant_oh  = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_idx      = W'(cand);
        grant_oh[cand] = 1'b1;
      end
    end
  end

  // Pointer at N-1 after reset makes channel 0 the first candidate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= W'(N - 1);
    end else if (advance && any_req) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/uart_tx_typed_chunk_arbiter.sv
// Multi-channel typed chunk sender: round-robin picks a channel and frames its
// chunk as 00 TT | escaped payload | 00 01 into a single UART TX byte engine.
module uart_tx_typed_chunk_arbiter
  import uart_tx_typed_chunk_arbiter_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int BUFFER_BYTES = 4,
  parameter int SIZE_W       = $clog2(BUFFER_BYTES + 1),
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CHANNELS-1:0]              ch_req,
  input  logic [CHANNELS*SIZE_W-1:0]       ch_size,
  input  logic [CHANNELS*8-1:0]            ch_type,
  input  logic [CHANNELS*BUFFER_BYTES*8-1:0] ch_bytes,
  output logic [CHANNELS-1:0]              ch_ack,
  output logic [CHANNELS-1:0]              ch_err,
  output logic                             tx_valid,
  output logic [7:0]                       tx_data,
  input  logic                             tx_done,
  output logic                             busy,
  output logic [CH_W-1:0]                  active_ch
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(BUFFER_BYTES);

  state_t                state;
  state_t                state_nxt;
  phase_t                phase;
  logic [CHANNELS-1:0]   active_oh;
  logic [7:0]            type_q;
  logic [SIZE_W-1:0]     size_q;
  logic [SIZE_W-1:0]     idx;
  logic                  esc_done;

  logic [CH_W-1:0]       arb_idx;
  logic [CHANNELS-1:0]   arb_oh;
  logic                  arb_any;
  logic                  arb_advance;

  logic [7:0]            sel_type;
  logic [SIZE_W-1:0]     sel_size;
  logic [SIZE_W-1:0]     size_clamped;
  logic [7:0]            cur_byte;
  logic                  esc_needed;
  logic                  last_payload;
  logic [7:0]            next_byte;

  assign arb_advance = (state == ST_IDLE);

  rr_arbiter #(
    .N (CHANNELS),
    .W (CH_W)
  ) u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req       (ch_req),
    .advance   (arb_advance),
    .grant_idx (arb_idx),
    .grant_oh  (arb_oh),
    .any_req   (arb_any)
  );

  // Payload is read live from the granted channel; only type/size are copied.
  always_comb begin
    sel_type = '0;
    sel_size = '0;
    cur_byte = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == active_ch) begin
        sel_type = ch_type[i*8 +: 8];
        sel_size = ch_size[i*SIZE_W +: SIZE_W];
        for (int unsigned k = 0; k < BUFFER_BYTES; k++) begin
          if (SIZE_W'(k) == idx) begin
            cur_byte = ch_bytes[(i*BUFFER_BYTES + k)*8 +: 8];
          end
        end
      end
    end
  end

  assign size_clamped = (sel_size > MAX_SIZE) ? MAX_SIZE : sel_size;
  assign esc_needed   = (phase == PH_PAYLOAD) && (cur_byte == ESC_BYTE) && !esc_done;
  assign last_payload = ((idx + SIZE_W'(1)) == size_q);

  always_comb begin
    next_byte = ESC_BYTE;
    case (phase)
      PH_HDR_ESC:  next_byte = ESC_BYTE;
      PH_HDR_TYPE: next_byte = type_q;
      PH_PAYLOAD:  next_byte = (cur_byte == ESC_BYTE) ? (esc_done ? ESC_NULL : ESC_BYTE)
                                                      : cur_byte;
      PH_EOC_ESC:  next_byte = ESC_BYTE;
      PH_EOC_VAL:  next_byte = ESC_EOC;
      default:     next_byte = ESC_BYTE;
    endcase
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    ch_ack    = '0;
    ch_err    = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (arb_any) state_nxt = ST_GRANT;
      end
      ST_GRANT:  state_nxt = is_reserved(sel_type) ? ST_REJECT : ST_LOAD;
      ST_REJECT: begin
        ch_err    = active_oh;
        state_nxt = ST_IDLE;
      end
      ST_LOAD:   state_nxt = ST_STROBE;
      ST_STROBE: begin
        tx_valid  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) state_nxt = (phase == PH_EOC_VAL) ? ST_ACK : ST_LOAD;
      end
      ST_ACK: begin
        ch_ack    = active_oh;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      phase     <= PH_HDR_ESC;
      active_ch <= '0;
      active_oh <= '0;
      type_q    <= '0;
      size_q    <= '0;
      idx       <= '0;
      esc_done  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            active_ch <= arb_idx;
            active_oh <= arb_oh;
          end
        end
        ST_GRANT: begin
          type_q   <= sel_type;
          size_q   <= size_clamped;
          phase    <= PH_HDR_ESC;
          idx      <= '0;
          esc_done <= 1'b0;
        end
        ST_LOAD: tx_data <= next_byte;
        ST_WAIT: begin
          if (tx_done) begin
            case (phase)
              PH_HDR_ESC:  phase <= PH_HDR_TYPE;
              PH_HDR_TYPE: phase <= (size_q == '0) ? PH_EOC_ESC : PH_PAYLOAD;
              PH_PAYLOAD: begin
                // A 00 payload byte is sent twice; the index only moves after the second.
                if (esc_needed) begin
                  esc_done <= 1'b1;
                end else begin
                  esc_done <= 1'b0;
                  idx      <= idx + SIZE_W'(1);
                  if (last_payload) phase <= PH_EOC_ESC;
                end
              end
              PH_EOC_ESC:  phase <= PH_EOC_VAL;
              default:     phase <= phase;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_typed_chunk_arbiter.sv
// Randomised scoreboard bench for the multi-channel typed chunk sender.
module tb_uart_tx_typed_chunk_arbiter;

  localparam int CH = 2;
  localparam int BB = 4;
  localparam int SW = $clog2(BB + 1);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [CH-1:0]     ch_req;
  logic [CH*SW-1:0]  ch_size;
  logic [CH*8-1:0]   ch_type;
  logic [CH*BB*8-1:0] ch_bytes;
  logic [CH-1:0]     ch_ack;
  logic [CH-1:0]     ch_err;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              busy;
  logic [CW-1:0]     active_ch;

  logic [7:0]        tb_type  [CH];
  logic [SW-1:0]     tb_size  [CH];
  logic [7:0]        tb_bytes [CH][BB];

  logic [7:0]        exp_bytes[$];
  logic [2*CH-1:0]   exp_evt[$];
  int                exp_ch[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                last_grant;
  int                strobe_cnt = 0;

  always #5 CLK = ~CLK;

  uart_tx_typed_chunk_arbiter #(
    .CHANNELS     (CH),
    .BUFFER_BYTES (BB),
    .SIZE_W       (SW),
    .CH_W         (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ch_req    (ch_req),
    .ch_size   (ch_size),
    .ch_type   (ch_type),
    .ch_bytes  (ch_bytes),
    .ch_ack    (ch_ack),
    .ch_err    (ch_err),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .active_ch (active_ch)
  );

  always_comb begin
    ch_size  = '0;
    ch_type  = '0;
    ch_bytes = '0;
    for (int i = 0; i < CH; i++) begin
      ch_size[i*SW +: SW] = tb_size[i];
      ch_type[i*8 +: 8]   = tb_type[i];
      for (int k = 0; k < BB; k++) ch_bytes[(i*BB + k)*8 +: 8] = tb_bytes[i][k];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: wire image of one chunk from the framing rules.
  function automatic void model(input int ch);
    logic [2*CH-1:0] ev;
    int n;
    ev = '0;
    if (tb_type[ch] < 8'h02) begin
      ev[CH + ch] = 1'b1;
    end else begin
      n = (int'(tb_size[ch]) > BB) ? BB : int'(tb_size[ch]);
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(tb_type[ch]);
      for (int k = 0; k < n; k++) begin
        if (tb_bytes[ch][k] == 8'h00) exp_bytes.push_back(8'h00);
        exp_bytes.push_back(tb_bytes[ch][k]);
      end
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h01);
      ev[ch] = 1'b1;
    end
    exp_evt.push_back(ev);
    exp_ch.push_back(ch);
  endfunction

  function automatic int next_grant(input logic [CH-1:0] m);
    int c;
    for (int off = 1; off <= CH; off++) begin
      c = (last_grant + off) % CH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Monitor / scoreboard consumer.
  always @(negedge CLK) begin
    if (!RST) begin
      if (tx_valid) begin
        strobe_cnt++;
        if (exp_bytes.size() == 0) fail_now("tx_unexpected");
        else check("tx_byte", tx_data, exp_bytes.pop_front());
      end
      if ((ch_ack | ch_err) != '0) begin
        if (exp_evt.size() == 0) begin
          fail_now("event_unexpected");
        end else begin
          check("event_err_ack", {ch_err, ch_ack}, exp_evt.pop_front());
          check("active_ch", active_ch, exp_ch.pop_front());
        end
      end
    end
  end

  // UART byte engine model: random latency, one tx_done pulse per strobe.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_valid && !RST) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        @(posedge CLK);
        #1 tx_done = 1'b1;
        @(posedge CLK);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic set_ch(input int ch, input logic [7:0] t, input logic [SW-1:0] s,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    tb_type[ch]     = t;
    tb_size[ch]     = s;
    tb_bytes[ch][0] = b0;
    tb_bytes[ch][1] = b1;
    tb_bytes[ch][2] = b2;
    tb_bytes[ch][3] = b3;
  endtask

  task automatic wait_event(input int ch);
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (ch_ack[ch] || ch_err[ch]) return;
    end
    fail_now("event_timeout");
  endtask

  // Hold mask for nch consecutive chunks; grant order predicted by round-robin.
  task automatic run_batch(input logic [CH-1:0] mask, input int nch);
    int order[$];
    int g;
    for (int k = 0; k < nch; k++) begin
      g = next_grant(mask);
      model(g);
      order.push_back(g);
      last_grant = g;
    end
    ch_req = mask;
    for (int k = 0; k < nch; k++) begin
      wait_event(order[k]);
      if (k == nch - 1) ch_req = '0;
      @(negedge CLK);
      check("busy_after_done", busy, 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_req     = '0;
    last_grant = CH - 1;
    for (int i = 0; i < CH; i++) set_ch(i, 8'h02, '0, 8'h00, 8'h00, 8'h00, 8'h00);

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ch_ack, '0);
    check("rst_err", ch_err, '0);
    check("rst_active_ch", active_ch, '0);
    RST = 1'b0;

    // Stray tx_done while idle must not disturb anything.
    @(posedge CLK); #1 tx_done = 1'b1;
    @(posedge CLK); #1 tx_done = 1'b0;
    @(negedge CLK);
    check("idle_busy", busy, 1'b0);

    set_ch(0, 8'h02, 3'd3, 8'h01, 8'h00, 8'h03, 8'h00);
    run_batch(2'b01, 1);
    set_ch(1, 8'h05, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_batch(2'b10, 1);
    set_ch(0, 8'h01, 3'd2, 8'h10, 8'h20, 8'h30, 8'h40);
    run_batch(2'b01, 1);
    set_ch(0, 8'h00, 3'd2, 8'h10, 8'h20, 8'h30, 8'h40);
    run_batch(2'b01, 1);
    set_ch(0, 8'h02, 3'd2, 8'h5A, 8'h00, 8'h00, 8'h00);
    set_ch(1, 8'h03, 3'd1, 8'h7E, 8'h00, 8'h00, 8'h00);
    run_batch(2'b11, 4);
    set_ch(0, 8'h02, 3'd7, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    run_batch(2'b01, 1);

    // Reset while the second payload byte is on the wire.
    set_ch(1, 8'h02, 3'd3, 8'h11, 8'h22, 8'h33, 8'h44);
    begin
      int s0;
      bit hit;
      s0  = strobe_cnt;
      hit = 1'b0;
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h02);
      exp_bytes.push_back(8'h11);
      exp_bytes.push_back(8'h22);
      ch_req = 2'b10;
      for (int i = 0; i < 400 && !hit; i++) begin
        @(negedge CLK);
        #1;
        if (strobe_cnt >= s0 + 4) hit = 1'b1;
      end
      if (!hit) fail_now("reset_test_timeout");
      RST    = 1'b1;
      ch_req = '0;
      @(negedge CLK);
      check("midrst_tx_valid", tx_valid, 1'b0);
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ack_err", {ch_err, ch_ack}, '0);
      check("midrst_active_ch", active_ch, '0);
      RST        = 1'b0;
      last_grant = CH - 1;
      repeat (10) @(negedge CLK);
    end
    set_ch(0, 8'h04, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00);
    set_ch(1, 8'h06, 3'd2, 8'h01, 8'h02, 8'h00, 8'h00);
    run_batch(2'b11, 1);

    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < CH; c++) begin
        tb_type[c] = 8'($urandom_range(0, 9));
        tb_size[c] = SW'($urandom_range(0, 7));
        for (int k = 0; k < BB; k++)
          tb_bytes[c][k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      run_batch(CH'($urandom_range(1, (1 << CH) - 1)), $urandom_range(1, 3));
    end

    repeat (10) @(negedge CLK);
    check("bytes_left", exp_bytes.size(), 0);
    check("events_left", exp_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
